full_event_monitor: RTL



---
 rtl/full_mon_pkg.sv | 13 +
 rtl/full_mon_fifo.sv | 56 +++++
 rtl/full_event_monitor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/full_mon_pkg.sv
// Shared types and constants for the full-event monitor (state encoding, widths).
package full_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TIMED_OUT
    } mon_state_t;

    localparam int PW_DEFAULT = 16;
    localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/full_mon_fifo.sv
// Synchronous show-ahead FIFO; a push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module full_mon_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/full_event_monitor.sv
// Measures cycles between rising edges of sig_in, queues them, and flags missing events.
// Optional FULL_MON_DROP_CNT_EN adds a saturating drop_cnt output counting discarded events.
module full_event_monitor
    import full_mon_pkg::*;
#(
    parameter int PW      = PW_DEFAULT,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 40000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_in,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [PW-1:0] ev_period,
    output logic          timeout,
    output logic          overflow
`ifdef FULL_MON_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};
    localparam logic [PW-1:0] TO_VAL  = PW'(TIMEOUT);

    mon_state_t    state;
    mon_state_t    next_state;
    logic          sig_q;
    logic          rise;
    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_next;
    logic [PW-1:0] elapsed;
    logic          push;
    logic          fifo_empty;
    logic          fifo_full;
    logic          dropped;

    assign rise    = sig_in & ~sig_q;
    assign elapsed = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sig_q <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            sig_q <= sig_in;
            cnt   <= cnt_next;
        end
    end

    // Every event after the first closes a period; a late event still reports its (possibly saturated) gap.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        push       = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    cnt_next   = '0;
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    push     = 1'b1;
                    cnt_next = '0;
                end else begin
                    cnt_next = elapsed;
                    if (elapsed >= TO_VAL) begin
                        next_state = TIMED_OUT;
                    end
                end
            end
            TIMED_OUT: begin
                if (rise) begin
                    push       = 1'b1;
                    cnt_next   = '0;
                    next_state = ARMED;
                end else begin
                    cnt_next = elapsed;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        timeout = (state == TIMED_OUT);
    end

    full_mon_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (elapsed),
        .pop   (ev_ready),
        .head  (ev_period),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign ev_valid = ~fifo_empty;
    assign dropped  = push & fifo_full & ~ev_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (dropped) begin
            overflow <= 1'b1;
        end
    end

`ifdef FULL_MON_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (dropped && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule
